// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Multiply keeps {partial_hi, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left, quotient bits entering at bit 0.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, opnd};
    if (!is_div)
      acc_next = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 34-cycle issue, {hi, lo} result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               kill,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  state_t             state, state_next;
  logic               launch;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
  logic [WIDTH-1:0]   opnd, a_mag, b_mag, quo, rmd;
  logic               is_div_r, sign_a, sign_b, b_zero;
  logic               signed_in, is_div_in;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_r),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    unique case (state)
      S_IDLE: if (start && !kill) begin
        state_next = S_CALC;
        launch     = 1'b1;
      end
      S_CALC: if (kill)                          state_next = S_IDLE;
              else if (count == CNT_W'(WIDTH-1)) state_next = S_FIX;
      S_FIX:  state_next = kill ? S_IDLE : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    is_div_in = op[1];
    signed_in = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
    a_mag     = (signed_in && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_in && b[WIDTH-1]) ? -b : b;
  end

  // Divide by zero leaves |a| in the remainder, so the normal remainder sign
  // fix reproduces the original a; only the quotient needs overriding.
  always_comb begin
    quo      = acc[WIDTH-1:0];
    rmd      = acc[2*WIDTH-1:WIDTH];
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    if (is_div_r) begin
      prod_fix[2*WIDTH-1:WIDTH] = sign_a ? -rmd : rmd;
      prod_fix[WIDTH-1:0]       = b_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_r <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      prod     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (launch) begin
        count    <= '0;
        acc      <= {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
        opnd     <= is_div_in ? b_mag : a_mag;
        is_div_r <= is_div_in;
        sign_a   <= signed_in & a[WIDTH-1];
        sign_b   <= signed_in & b[WIDTH-1];
        b_zero   <= (b == '0);
      end else if (state == S_CALC) begin
        count <= count + 1'b1;
        acc   <= acc_next;
      end
      if (state == S_FIX && !kill) prod <= prod_fix;
      busy <= (state_next == S_CALC) || (state_next == S_FIX);
      done <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus kill/start/reset sequences.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .kill  (kill),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
    end
  endtask

  // Call just after a negedge; start is sampled at the next posedge (edge T).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output int lat, output int bcnt, output int both);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0; bcnt = 0; both = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    if (busy && done) both++;
    p = prod;
  endtask

  initial begin
    logic [63:0] p, prev;
    int lat, bcnt, both, dcnt;

    vecs[0]  = '{2'b01, 32'd7,         32'd6,         64'h00000000_0000002A};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD,  32'd5,         64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD};
    vecs[4]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000};
    vecs[5]  = '{2'b11, 32'd100,       32'd0,         64'h00000064_FFFFFFFF};
    vecs[6]  = '{2'b10, 32'hFFFFFF9C,  32'd0,         64'hFFFFFF9C_FFFFFFFF};
    vecs[7]  = '{2'b11, 32'd100,       32'd7,         64'h00000002_0000000E};
    vecs[8]  = '{2'b00, 32'h80000000,  32'h80000000,  64'h40000000_00000000};
    vecs[9]  = '{2'b00, 32'hFFFFFFFD,  32'hFFFFFFFB,  64'h00000000_0000000F};
    vecs[10] = '{2'b10, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD};
    vecs[11] = '{2'b11, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF};
    vecs[12] = '{2'b00, 32'd0,         32'hFFFFFFFF,  64'h00000000_00000000};

    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_prod", prod, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, p, lat, bcnt, both);
      check($sformatf("vec%0d_prod", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      check($sformatf("vec%0d_busy_and_done", i), 64'(both), 64'd0);
      @(negedge clock);
      check($sformatf("vec%0d_done_pulse", i), {62'd0, busy, done}, 64'd0);
    end

    // Kill at T+10 of MULTU 3x3, then restart at T+11.
    prev = prod;
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    kill = 1'b1;
    @(posedge clock);
    @(negedge clock);
    kill = 1'b0;
    check("kill_idle", {62'd0, busy, done}, 64'd0);
    check("kill_prod_kept", prod, prev);
    run_op(2'b01, 32'd3, 32'd3, p, lat, bcnt, both);
    check("restart_prod", p, 64'd9);
    check("restart_latency", 64'(lat), 64'd33);
    @(negedge clock);

    // start while busy is ignored.
    op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; lat = 0;
    while (!done && lat < 60) begin
      if (lat == 5) begin op = 2'b11; a = 32'd100; b = 32'd0; start = 1'b1; end
      else start = 1'b0;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check("busy_start_prod", prod, 64'd25);
    check("busy_start_latency", 64'(lat), 64'd33);
    @(negedge clock);

    // kill together with start in IDLE: nothing launches.
    prev = prod;
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; kill = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", {63'd0, busy}, 64'd0);
    dcnt = 0;
    repeat (36) begin
      @(negedge clock);
      if (done || busy) dcnt++;
    end
    check("kill_start_no_activity", 64'(dcnt), 64'd0);
    check("kill_start_prod", prod, prev);

    // Asynchronous reset in the middle of a DIVU.
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_prod", prod, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(2'b11, 32'd100, 32'd7, p, lat, bcnt, both);
    check("post_reset_prod", p, 64'h00000002_0000000E);
    check("post_reset_latency", 64'(lat), 64'd33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
